// File: rtl/booth_share_arbiter_module_pkg.sv
// Shared definitions for the booth multiplier and the controllers that share it:
// controller state encoding, default operand width and wait budget.
package booth_share_arbiter_module_pkg;

  localparam int BOOTH_WIDTH_DEF   = 8;
  localparam int BOOTH_TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Encoding of the last-served flag: which requester owned the previous operation.
  localparam logic LAST_REQ0 = 1'b0;
  localparam logic LAST_REQ1 = 1'b1;

endpackage

// File: rtl/booth_share_arbiter_module_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// requester that was not served last wins.
module booth_rr_pick_module
  import booth_share_arbiter_module_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_served,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req0 && req1) begin
      pick = (last_served == LAST_REQ1) ? 2'b01 : 2'b10;
    end else if (req0) begin
      pick = 2'b01;
    end else if (req1) begin
      pick = 2'b10;
    end
  end

endmodule

// File: rtl/booth_share_arbiter_module.sv
// Arbitrates two requesters onto one shared booth multiplier, with a bounded
// wait for the multiplier and a one-cycle done pulse back to the owner.
module booth_share_arbiter_module
  import booth_share_arbiter_module_pkg::*;
#(
  parameter int WIDTH   = BOOTH_WIDTH_DEF,
  parameter int TIMEOUT = BOOTH_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_start_sig,
  input  logic [WIDTH-1:0]   req0_A,
  input  logic [WIDTH-1:0]   req0_B,
  output logic               req0_done_sig,
  output logic [2*WIDTH-1:0] req0_product,
  input  logic               req1_start_sig,
  input  logic [WIDTH-1:0]   req1_A,
  input  logic [WIDTH-1:0]   req1_B,
  output logic               req1_done_sig,
  output logic [2*WIDTH-1:0] req1_product,
  output logic               mul_start_sig,
  output logic [WIDTH-1:0]   mul_A,
  output logic [WIDTH-1:0]   mul_B,
  input  logic               mul_done_sig,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [1:0]         grant,
  output logic               timeout_sig
);

  // state | meaning
  // IDLE  | no owner; pick a requester and latch its operands
  // ISSUE | raise mul_start_sig, load the wait budget
  // WAIT  | multiplier busy; finish on mul_done_sig or on budget expiry
  // DONE  | owner's done_sig (and timeout_sig if aborted) high for this cycle

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t         state_q, state_nx;
  logic [1:0]         pick;
  logic               last_q;
  logic [CW-1:0]      cnt_q;
  logic               take, issue, finish_ok, finish_to, retire;
  logic [2*WIDTH-1:0] result;

  booth_rr_pick_module u_pick (
    .req0        (req0_start_sig),
    .req1        (req1_start_sig),
    .last_served (last_q),
    .pick        (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx  = state_q;
    take      = 1'b0;
    issue     = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          take     = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue    = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the last budgeted cycle still counts as success.
        if (mul_done_sig) begin
          finish_ok = 1'b1;
          state_nx  = ST_DONE;
        end else if (cnt_q == CW'(1)) begin
          finish_to = 1'b1;
          state_nx  = ST_DONE;
        end
      end
      ST_DONE: begin
        retire   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign result = finish_ok ? mul_product : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= 2'b00;
      last_q        <= LAST_REQ1;
      mul_A         <= '0;
      mul_B         <= '0;
      mul_start_sig <= 1'b0;
      cnt_q         <= '0;
      req0_done_sig <= 1'b0;
      req1_done_sig <= 1'b0;
      req0_product  <= '0;
      req1_product  <= '0;
      timeout_sig   <= 1'b0;
    end else begin
      if (take) begin
        grant <= pick;
        mul_A <= pick[0] ? req0_A : req1_A;
        mul_B <= pick[0] ? req0_B : req1_B;
      end
      if (issue) begin
        mul_start_sig <= 1'b1;
        cnt_q         <= CW'(TIMEOUT);
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (finish_ok || finish_to) begin
        mul_start_sig <= 1'b0;
        timeout_sig   <= finish_to;
        if (grant[0]) begin
          req0_product  <= result;
          req0_done_sig <= 1'b1;
        end else begin
          req1_product  <= result;
          req1_done_sig <= 1'b1;
        end
      end
      if (retire) begin
        req0_done_sig <= 1'b0;
        req1_done_sig <= 1'b0;
        timeout_sig   <= 1'b0;
        grant         <= 2'b00;
        last_q        <= grant[1] ? LAST_REQ1 : LAST_REQ0;
      end
    end
  end

endmodule
